// File: rtl/rf_pkg.sv
// Shared defaults and per-port bus slicing helpers for the scoreboarded register file.
package rf_pkg;

    localparam int RF_DATA_W  = 32;
    localparam int RF_ADDR_W  = 5;
    localparam int RF_PEND_W  = 2;
    // Widest flattened port bus the helpers handle (4 ports x 32 bits fits with room to spare).
    localparam int RF_MAX_BUS = 256;

    function automatic logic [RF_MAX_BUS-1:0] rf_get_slice(
        input logic [RF_MAX_BUS-1:0] bus,
        input int                    k,
        input int                    w
    );
        logic [RF_MAX_BUS-1:0] mask;
        mask = (RF_MAX_BUS'(1) << w) - RF_MAX_BUS'(1);
        return (bus >> (k * w)) & mask;
    endfunction

    function automatic logic [RF_MAX_BUS-1:0] rf_put_slice(
        input logic [RF_MAX_BUS-1:0] bus,
        input int                    k,
        input int                    w,
        input logic [RF_MAX_BUS-1:0] val
    );
        logic [RF_MAX_BUS-1:0] mask;
        mask = ((RF_MAX_BUS'(1) << w) - RF_MAX_BUS'(1)) << (k * w);
        return (bus & ~mask) | ((val << (k * w)) & mask);
    endfunction

endpackage

// File: rtl/rf_pend_ctr.sv
// One per-register pending-write counter: counts issued-but-unretired writes, never wraps.
module rf_pend_ctr
#(
    parameter int PEND_W = 2
)(
    input  logic              CLK,
    input  logic              RST,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] cnt,
    output logic              full
);

    logic dec_ok;

    assign full   = &cnt;
    assign dec_ok = dec && (cnt != '0);

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (inc && !dec_ok && !full) begin
            cnt <= cnt + PEND_W'(1);
        end else if (dec_ok && !inc) begin
            cnt <= cnt - PEND_W'(1);
        end
    end

endmodule

// File: rtl/rf_scoreboard.sv
// Multi-port register file with optional zero register, write bypass and a
// per-register pending-write scoreboard for RAW hazard detection at issue.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int N_RD     = 2,
    parameter int PEND_W   = RF_PEND_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
)(
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     W,
    input  logic [ADDR_W-1:0]        W_reg,
    input  logic [DATA_W-1:0]        W_data,
    input  logic [N_RD*ADDR_W-1:0]   R_reg,
    output logic [N_RD*DATA_W-1:0]   R_data,
    output logic [N_RD-1:0]          R_busy,
    input  logic                     Issue,
    input  logic [ADDR_W-1:0]        Issue_reg,
    output logic                     Issue_full
);

    localparam int DEPTH    = 2**ADDR_W;
    localparam int RD_BUS_W = N_RD * DATA_W;

    logic [DATA_W-1:0] regs   [DEPTH];
    logic [PEND_W-1:0] cnt    [DEPTH];
    logic [DEPTH-1:0]  full;
    logic [DATA_W-1:0] rd_val [N_RD];
    logic              write_zero;

    assign write_zero = (ZERO_REG != 0) && (W_reg == '0);

    // A retiring write in the same cycle does not relieve the stall.
    assign Issue_full = Issue && full[Issue_reg];

    // NOTE: every entry is reset because reads after RST must return 0, not stale data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (W && !write_zero) begin
            regs[W_reg] <= W_data;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ctr
        if ((ZERO_REG != 0) && (i == 0)) begin : g_tie
            assign cnt[i]  = '0;
            assign full[i] = 1'b0;
        end else begin : g_cnt
            logic inc;
            logic dec;
            assign inc = Issue && !Issue_full && (Issue_reg == ADDR_W'(i));
            assign dec = W && (W_reg == ADDR_W'(i));
            rf_pend_ctr #(.PEND_W(PEND_W)) u_ctr (
                .CLK  (CLK),
                .RST  (RST),
                .inc  (inc),
                .dec  (dec),
                .cnt  (cnt[i]),
                .full (full[i])
            );
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              zero_hit;
        logic              hit;
        logic [DATA_W-1:0] val;

        assign addr     = ADDR_W'(rf_get_slice(RF_MAX_BUS'(R_reg), k, ADDR_W));
        assign zero_hit = (ZERO_REG != 0) && (addr == '0);
        assign hit      = (BYPASS != 0) && W && (W_reg == addr) && !zero_hit;

        // NOTE: default assignment first so no path leaves val unassigned (no latch).
        always_comb begin
            val = regs[addr];
            if (RST || zero_hit) begin
                val = '0;
            end else if (hit) begin
                val = W_data;
            end
        end

        assign rd_val[k] = val;
        // Busy only if writes remain outstanding once a bypassed write retires this cycle.
        assign R_busy[k] = !zero_hit && (cnt[addr] > PEND_W'(hit));
    end

    always_comb begin
        R_data = '0;
        for (int k = 0; k < N_RD; k++) begin
            R_data = RD_BUS_W'(rf_put_slice(RF_MAX_BUS'(R_data), k, DATA_W,
                                            RF_MAX_BUS'(rd_val[k])));
        end
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench: one bypass/zero-reg instance and one plain instance, both 4 read ports.
module tb_rf_scoreboard;

    logic         CLK = 1'b0;
    logic         RST;
    logic         W;
    logic [4:0]   W_reg;
    logic [31:0]  W_data;
    logic [19:0]  R_reg;
    logic         Issue;
    logic [4:0]   Issue_reg;

    logic [127:0] a_data, b_data;
    logic [3:0]   a_busy, b_busy;
    logic         a_full, b_full;

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    rf_scoreboard #(.N_RD(4)) dut_a (
        .CLK(CLK), .RST(RST), .W(W), .W_reg(W_reg), .W_data(W_data),
        .R_reg(R_reg), .R_data(a_data), .R_busy(a_busy),
        .Issue(Issue), .Issue_reg(Issue_reg), .Issue_full(a_full)
    );

    rf_scoreboard #(.N_RD(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .CLK(CLK), .RST(RST), .W(W), .W_reg(W_reg), .W_data(W_data),
        .R_reg(R_reg), .R_data(b_data), .R_busy(b_busy),
        .Issue(Issue), .Issue_reg(Issue_reg), .Issue_full(b_full)
    );

    typedef struct {
        logic        w;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  rr0, rr1;
        logic        iss;
        logic [4:0]  ir;
        logic [31:0] ea0, ea1;
        logic [1:0]  eab;
        logic        eaf;
        logic [31:0] eb0, eb1;
        logic [1:0]  ebb;
        logic        ebf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic w, input logic [4:0] wr, input logic [31:0] wd,
        input logic [4:0] rr0, input logic [4:0] rr1,
        input logic iss, input logic [4:0] ir,
        input logic [31:0] ea0, input logic [31:0] ea1, input logic [1:0] eab, input logic eaf,
        input logic [31:0] eb0, input logic [31:0] eb1, input logic [1:0] ebb, input logic ebf
    );
        vec_t v;
        v.w = w; v.wr = wr; v.wd = wd; v.rr0 = rr0; v.rr1 = rr1; v.iss = iss; v.ir = ir;
        v.ea0 = ea0; v.ea1 = ea1; v.eab = eab; v.eaf = eaf;
        v.eb0 = eb0; v.eb1 = eb1; v.ebb = ebb; v.ebf = ebf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Ports 2/3 read the same addresses as ports 0/1.
    task automatic set_in(input logic w, input logic [4:0] wr, input logic [31:0] wd,
                          input logic [4:0] rr0, input logic [4:0] rr1,
                          input logic iss, input logic [4:0] ir);
        W = w; W_reg = wr; W_data = wd;
        R_reg = {rr1, rr0, rr1, rr0};
        Issue = iss; Issue_reg = ir;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("v%0d a_data%0d", i, k), a_data[k*32 +: 32], (k % 2 == 0) ? v.ea0 : v.ea1);
        end
        check($sformatf("v%0d a_busy", i), 32'(a_busy), 32'({v.eab, v.eab}));
        check($sformatf("v%0d a_full", i), 32'(a_full), 32'(v.eaf));
        check($sformatf("v%0d b_data0", i), b_data[31:0], v.eb0);
        check($sformatf("v%0d b_data1", i), b_data[63:32], v.eb1);
        check($sformatf("v%0d b_busy", i), 32'(b_busy), 32'({v.ebb, v.ebb}));
        check($sformatf("v%0d b_full", i), 32'(b_full), 32'(v.ebf));
    endtask

    initial begin
        RST = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);

        //             w  wr  wd            rr0 rr1 iss ir  ea0           ea1           eab    eaf  eb0           eb1           ebb    ebf
        vecs.push_back(mk(0, 0, 32'h0,        0,  1, 0, 0,  32'h0,        32'h0,        2'b00, 0,  32'h0,        32'h0,        2'b00, 0));
        vecs.push_back(mk(1, 7, 32'h12345678, 7,  7, 0, 0,  32'h12345678, 32'h12345678, 2'b00, 0,  32'h0,        32'h0,        2'b00, 0));
        vecs.push_back(mk(0, 0, 32'h0,        7,  7, 0, 0,  32'h12345678, 32'h12345678, 2'b00, 0,  32'h12345678, 32'h12345678, 2'b00, 0));
        vecs.push_back(mk(1, 0, 32'hFFFFFFFF, 0,  0, 1, 0,  32'h0,        32'h0,        2'b00, 0,  32'h0,        32'h0,        2'b00, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0,  0, 0, 0,  32'h0,        32'h0,        2'b00, 0,  32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 0));
        vecs.push_back(mk(0, 0, 32'h0,        3,  0, 1, 3,  32'h0,        32'h0,        2'b00, 0,  32'h0,        32'hFFFFFFFF, 2'b10, 0));
        vecs.push_back(mk(0, 0, 32'h0,        3,  0, 1, 3,  32'h0,        32'h0,        2'b01, 0,  32'h0,        32'hFFFFFFFF, 2'b11, 0));
        vecs.push_back(mk(0, 0, 32'h0,        3,  0, 1, 3,  32'h0,        32'h0,        2'b01, 0,  32'h0,        32'hFFFFFFFF, 2'b11, 0));
        vecs.push_back(mk(0, 0, 32'h0,        3,  0, 1, 3,  32'h0,        32'h0,        2'b01, 1,  32'h0,        32'hFFFFFFFF, 2'b11, 1));
        vecs.push_back(mk(1, 3, 32'h33,       3,  0, 1, 3,  32'h33,       32'h0,        2'b01, 1,  32'h0,        32'hFFFFFFFF, 2'b11, 1));
        vecs.push_back(mk(1, 3, 32'h34,       3,  0, 0, 0,  32'h34,       32'h0,        2'b01, 0,  32'h33,       32'hFFFFFFFF, 2'b11, 0));
        vecs.push_back(mk(1, 3, 32'h35,       3,  0, 0, 0,  32'h35,       32'h0,        2'b00, 0,  32'h34,       32'hFFFFFFFF, 2'b11, 0));
        vecs.push_back(mk(0, 0, 32'h0,        3,  0, 0, 0,  32'h35,       32'h0,        2'b00, 0,  32'h35,       32'hFFFFFFFF, 2'b10, 0));
        vecs.push_back(mk(0, 0, 32'h0,        9,  9, 1, 9,  32'h0,        32'h0,        2'b00, 0,  32'h0,        32'h0,        2'b00, 0));
        vecs.push_back(mk(1, 9, 32'h99,       9,  9, 1, 9,  32'h99,       32'h99,       2'b00, 0,  32'h0,        32'h0,        2'b11, 0));
        vecs.push_back(mk(0, 0, 32'h0,        9,  9, 0, 0,  32'h99,       32'h99,       2'b11, 0,  32'h99,       32'h99,       2'b11, 0));
        vecs.push_back(mk(1, 9, 32'h9A,       9,  9, 0, 0,  32'h9A,       32'h9A,       2'b00, 0,  32'h99,       32'h99,       2'b11, 0));
        vecs.push_back(mk(0, 0, 32'h0,        9,  9, 0, 0,  32'h9A,       32'h9A,       2'b00, 0,  32'h9A,       32'h9A,       2'b00, 0));
        vecs.push_back(mk(1, 10, 32'hA0,      10, 10, 0, 0, 32'hA0,       32'hA0,       2'b00, 0,  32'h0,        32'h0,        2'b00, 0));
        vecs.push_back(mk(0, 0, 32'h0,        10, 10, 0, 0, 32'hA0,       32'hA0,       2'b00, 0,  32'hA0,       32'hA0,       2'b00, 0));
        vecs.push_back(mk(0, 0, 32'h0,        10, 10, 1, 10, 32'hA0,      32'hA0,       2'b00, 0,  32'hA0,       32'hA0,       2'b00, 0));
        vecs.push_back(mk(0, 0, 32'h0,        10, 10, 0, 0, 32'hA0,       32'hA0,       2'b11, 0,  32'hA0,       32'hA0,       2'b11, 0));
        vecs.push_back(mk(1, 1, 32'h1111,     1,  2, 0, 0,  32'h1111,     32'h0,        2'b00, 0,  32'h0,        32'h0,        2'b00, 0));
        vecs.push_back(mk(1, 2, 32'h2222,     1,  2, 0, 0,  32'h1111,     32'h2222,     2'b00, 0,  32'h1111,     32'h0,        2'b00, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1,  2, 0, 0,  32'h1111,     32'h2222,     2'b00, 0,  32'h1111,     32'h2222,     2'b00, 0));
        vecs.push_back(mk(0, 0, 32'h0,        2,  1, 0, 0,  32'h2222,     32'h1111,     2'b00, 0,  32'h2222,     32'h1111,     2'b00, 0));

        #12 RST = 1'b0;
        @(posedge CLK); #1;

        foreach (vecs[i]) begin
            set_in(vecs[i].w, vecs[i].wr, vecs[i].wd, vecs[i].rr0, vecs[i].rr1, vecs[i].iss, vecs[i].ir);
            @(negedge CLK);
            check_vec(i, vecs[i]);
            @(posedge CLK); #1;
        end

        // Reset mid-cycle: r5 written and issued, r10 still has one pending write.
        set_in(1, 5, 32'hDEADBEEF, 5, 10, 0, 0);
        @(posedge CLK); #1;
        set_in(0, 0, 32'h0, 5, 10, 1, 5);
        @(posedge CLK); #1;
        set_in(0, 0, 32'h0, 5, 10, 0, 0);
        #2;
        check("pre_rst a_data0", a_data[31:0], 32'hDEADBEEF);
        check("pre_rst a_busy", 32'(a_busy), 32'hF);

        RST = 1'b1;
        set_in(1, 5, 32'h55, 5, 10, 1, 5);
        #1;
        check("rst a_data0", a_data[31:0], 32'h0);
        check("rst a_data1", a_data[63:32], 32'h0);
        check("rst b_data0", b_data[31:0], 32'h0);
        check("rst a_busy", 32'(a_busy), 32'h0);
        check("rst b_busy", 32'(b_busy), 32'h0);
        check("rst a_full", 32'(a_full), 32'h0);
        check("rst b_full", 32'(b_full), 32'h0);

        @(posedge CLK); #2;
        RST = 1'b0;
        set_in(0, 0, 32'h0, 5, 3, 1, 5);
        @(negedge CLK);
        check("post_rst a_full", 32'(a_full), 32'h0);
        check("post_rst b_full", 32'(b_full), 32'h0);
        check("post_rst a_busy", 32'(a_busy), 32'h0);
        check("post_rst a_r5", a_data[31:0], 32'h0);
        check("post_rst a_r3", a_data[63:32], 32'h0);
        check("post_rst b_r3", b_data[63:32], 32'h0);

        @(posedge CLK); #1;
        set_in(0, 0, 32'h0, 5, 3, 0, 0);
        #1;
        check("post_rst a_busy r5", 32'(a_busy[0]), 32'h1);
        check("post_rst b_busy r5", 32'(b_busy[0]), 32'h1);
        check("post_rst a_busy r3", 32'(a_busy[1]), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
Parametrised register file for the pipelined CPU, successor to the single-cycle 32x32 file. It provides N_RD combinational read ports, one synchronous write port, an optional hard-wired zero register and an optional write-to-read bypass. A per-register pending-write scoreboard lets the issue stage detect RAW hazards and stall.

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
N_RD, 2, number of read ports (1..4)
PEND_W, 2, width of each per-register pending-write counter
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and issues, never busy
BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  asynchronous, active-high reset
W  input  1  write enable (writeback)
W_reg  input  ADDR_W  write address
W_data  input  DATA_W  write data
R_reg  input  N_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
R_data  output  N_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W]
R_busy  output  N_RD  port k's register still has an outstanding write after this cycle
Issue  input  1  an instruction writing Issue_reg is dispatched this cycle
Issue_reg  input  ADDR_W  destination of the issued instruction
Issue_full  output  1  Issue_reg's pending counter is saturated; the issue must stall

Behaviour:
- Reset: CLK and RST only; RST is asynchronous and active-high. Asserting RST immediately clears all registers and all pending counters to 0, regardless of CLK. While RST is high, every R_data is 0, R_busy is 0 and Issue_full is 0. The first write is accepted on the first rising edge after RST deasserts.
- Write: on posedge CLK with W=1, Reg[W_reg] <= W_data. With ZERO_REG=1 and W_reg=0, the write is dropped.
- Read: purely combinational, zero latency.
  - Base value: R_data[k] = Reg[R_reg[k]].
  - If BYPASS=1, W=1, W_reg==R_reg[k], and the zero-register exception does not apply, R_data[k] = W_data in the same cycle.
  - If BYPASS=0, the new value is visible the cycle after the write.
- Zero register: with ZERO_REG=1, R_reg[k]=0 always returns 0 and R_busy[k]=0.
- Pending counter (one per register, PEND_W bits, unsigned), posedge update, evaluated on the same register:
  - inc = Issue and not Issue_full and not (ZERO_REG and Issue_reg==0)
  - dec = W and counter!=0 (and not the zero register)
  - inc only: cnt+1. dec only: cnt-1. Both on the same register: unchanged.
  - A write to a register whose counter is 0 is legal: data is written and the counter stays 0, with no underflow.
- Issue_full = Issue and counter[Issue_reg] == 2**PEND_W-1, combinational. A stalled issue does not increment. A write retiring the same register in that cycle does not clear Issue_full (conservative stall).
- R_busy[k] (combinational), with hit = BYPASS and W and W_reg==R_reg[k]:
  - R_busy[k] = (counter[R_reg[k]] - hit) != 0.
  - With BYPASS=0: R_busy[k] = counter[R_reg[k]] != 0.
  - A same-cycle Issue to R_reg[k] does not affect R_busy[k] this cycle.
- Multiple read ports reading the same address behave identically and independently.
- Wrap-around: counters never wrap; saturation is prevented by Issue_full, and underflow by the counter!=0 guard.

Decomposition:
- Package rf_pkg holds:
  - default constants: RF_DATA_W=32, RF_ADDR_W=5, RF_PEND_W=2
  - a function packing and unpacking per-port address/data slices
- Sub-module rf_pend_ctr: one PEND_W-bit saturating up/down counter with inc, dec and async RST inputs and cnt and full outputs. It is instantiated 2**ADDR_W times by a generate loop; entry 0 is tied off when ZERO_REG=1.
- The storage array and read muxes stay in the top level.

Test Plan:
- Reset mid-run: write 0xDEADBEEF to r5, issue r5, then assert RST between edges → R_data for r5 is 0 and R_busy is 0 immediately, before the next edge; after release, Issue_full is 0.
- Bypass: W=1, W_reg=7, W_data=0x12345678, R_reg port0=7 in the same cycle → port0 reads 0x12345678 combinationally. With BYPASS=0 it reads the old value, and 0x12345678 appears the next cycle.
- Zero register: write 0xFFFFFFFF to r0 and Issue r0 → r0 reads 0, R_busy is 0, and no counter changes. With ZERO_REG=0 the same write is read back as 0xFFFFFFFF.
- Scoreboard: Issue r3 three times (PEND_W=2) → R_busy=1 on r3; a 4th Issue of r3 gives Issue_full=1 and the counter stays 3. Three writes to r3 → R_busy stays 1 until the cycle of the 3rd write (with bypass), then 0.
- Simultaneous events: counter[r9]=1, Issue r9 and W r9 in the same cycle → the counter stays 1. A write to r10 with counter 0 → data updated, counter stays 0.
- Multiport: N_RD=4, all ports reading r1 and r2 alternately after distinct writes → each port returns the correct value independently.
